// File: rtl/pc_gen_unit.sv
// PC owner for the multi-cycle core: issues fetches over valid/ready, waits for
// execute to resolve, then selects the next PC with misaligned-target trapping.
module pc_gen_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     IALIGN   = 4,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [XLEN-1:0]   fetch_pc,
  input  logic              res_valid,
  input  logic [2:0]        branch,
  input  logic              zero,
  input  logic              less,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   mtvec,
  input  logic              halt,
  output logic              trap_valid,
  output logic [XLEN-1:0]   trap_pc,
  output logic [1:0]        pc_src,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [1:0]      SRC_SEQ   = 2'b00;
  localparam logic [1:0]      SRC_REL   = 2'b01;
  localparam logic [1:0]      SRC_JR    = 2'b10;
  localparam logic [1:0]      SRC_TRAP  = 2'b11;
  localparam logic [XLEN-1:0] STEP      = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] JR_MSK    = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] VEC_MSK   = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jr_pc;
  logic [XLEN-1:0] target;
  logic [1:0]      sel;
  logic            misalign;

  assign fetch_pc = pc;

  always_comb begin
    seq_pc = pc + STEP;
    rel_pc = pc + imm;
    jr_pc  = (rs1 + imm) & JR_MSK;
    sel    = SRC_SEQ;
    unique case (branch)
      3'b001:  sel = SRC_REL;
      3'b010:  sel = SRC_JR;
      3'b100:  sel = zero  ? SRC_REL : SRC_SEQ;
      3'b101:  sel = zero  ? SRC_SEQ : SRC_REL;
      3'b110:  sel = less  ? SRC_REL : SRC_SEQ;
      3'b111:  sel = less  ? SRC_SEQ : SRC_REL;
      default: sel = SRC_SEQ;
    endcase
    unique case (sel)
      SRC_REL: target = rel_pc;
      SRC_JR:  target = jr_pc;
      default: target = seq_pc;
    endcase
    // Sequential PC is always aligned, so only taken targets can trap.
    misalign = (sel != SRC_SEQ) && ((target & ALIGN_MSK) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      trap_valid  <= 1'b0;
      trap_pc     <= '0;
      pc_src      <= SRC_SEQ;
      halted      <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      trap_valid <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          if (halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state       <= ST_FETCH;
            fetch_valid <= 1'b1;
          end
        end
        ST_FETCH: begin
          // A handshake in the same cycle takes priority over halt.
          if (fetch_ready) begin
            state       <= ST_EXEC;
            fetch_valid <= 1'b0;
          end else if (halt) begin
            state       <= ST_HALT;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (res_valid) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
            if (misalign) begin
              pc         <= mtvec & VEC_MSK;
              pc_src     <= SRC_TRAP;
              trap_pc    <= target;
              trap_valid <= 1'b1;
            end else begin
              pc     <= target;
              pc_src <= sel;
            end
            if (halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              fetch_valid <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: two instances (IALIGN=4/CNT_W=32 and
// IALIGN=2/CNT_W=4) share stimulus; a reference model predicts each resolution.
module tb_pc_gen_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] MTVEC  = 32'h0000_0103;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [2:0]  branch = '0;
  logic        zero = 1'b0;
  logic        less = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] mtvec = MTVEC;
  logic        halt = 1'b0;

  logic        fv_a, tv_a, hlt_a, fv_b, tv_b, hlt_b;
  logic [31:0] fpc_a, tpc_a, cnt_a, fpc_b, tpc_b;
  logic [1:0]  src_a, src_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv_a), .fetch_ready(fetch_ready),
    .fetch_pc(fpc_a), .res_valid(res_valid), .branch(branch), .zero(zero),
    .less(less), .imm(imm), .rs1(rs1), .mtvec(mtvec), .halt(halt),
    .trap_valid(tv_a), .trap_pc(tpc_a), .pc_src(src_a), .halted(hlt_a),
    .retire_cnt(cnt_a));

  pc_gen_unit #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fv_b), .fetch_ready(fetch_ready),
    .fetch_pc(fpc_b), .res_valid(res_valid), .branch(branch), .zero(zero),
    .less(less), .imm(imm), .rs1(rs1), .mtvec(mtvec), .halt(halt),
    .trap_valid(tv_b), .trap_pc(tpc_b), .pc_src(src_b), .halted(hlt_b),
    .retire_cnt(cnt_b));

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  src;
    logic        tv;
    logic [31:0] tpc;
    logic        halted;
    logic [31:0] cnt;
  } rec_t;

  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic        tv;
    logic [31:0] tpc;
    logic [1:0]  src;
    logic        halted;
    logic [31:0] cnt;
  } out_t;

  int errors = 0;
  int checks = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  logic [31:0] m_pc[2];
  logic [31:0] m_cnt[2];
  logic [31:0] m_tpc[2];
  logic        prev_fv[2];
  logic        prev_h[2];
  logic [31:0] cur_pc[2];

  // Reference: decide taken/not-taken from the branch rules, then check alignment by modulo.
  function automatic rec_t predict(input logic [31:0] pc, input logic [31:0] cnt_in,
                                   input logic [31:0] tpc_in, input int ialign,
                                   input longint cmod, input logic [2:0] br,
                                   input logic z, input logic l, input logic [31:0] im,
                                   input logic [31:0] r1, input logic h);
    rec_t   e;
    bit     taken;
    bit     is_jr;
    logic [31:0] tgt;
    longint c;
    taken = 1'b0;
    is_jr = 1'b0;
    case (br)
      3'd1: taken = 1'b1;
      3'd2: begin taken = 1'b1; is_jr = 1'b1; end
      3'd4: taken = z;
      3'd5: taken = !z;
      3'd6: taken = l;
      3'd7: taken = !l;
      default: taken = 1'b0;
    endcase
    e.tv  = 1'b0;
    e.tpc = tpc_in;
    if (!taken) begin
      e.pc  = pc + 32'd4;
      e.src = 2'd0;
    end else begin
      tgt = is_jr ? ((r1 + im) & 32'hFFFF_FFFE) : (pc + im);
      if ((tgt % ialign) != 0) begin
        e.pc  = mtvec & 32'hFFFF_FFFC;
        e.src = 2'd3;
        e.tv  = 1'b1;
        e.tpc = tgt;
      end else begin
        e.pc  = tgt;
        e.src = is_jr ? 2'd2 : 2'd1;
      end
    end
    c = (longint'(cnt_in) + 1) % cmod;
    e.cnt    = c[31:0];
    e.halted = h;
    return e;
  endfunction

  task automatic mon_side(input int w, input out_t o);
    rec_t e;
    bit   ev;
    bit   have;
    ev = (o.fv && !prev_fv[w]) || (o.halted && !prev_h[w]);
    if (ev) begin
      checks++;
      have = 1'b0;
      if (w == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      if (w == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      if (!have) begin
        errors++;
        $display("FAIL unexpected_output dut%0d fetch_pc=%h halted=%b (no expectation queued)",
                 w, o.pc, o.halted);
      end else begin
        if (o.pc !== e.pc || o.src !== e.src || o.tv !== e.tv || o.tpc !== e.tpc ||
            o.halted !== e.halted || o.cnt !== e.cnt || o.fv !== !e.halted) begin
          errors++;
          $display("FAIL resolve dut%0d got pc=%h src=%0d tv=%b tpc=%h halted=%b cnt=%0d fv=%b expected pc=%h src=%0d tv=%b tpc=%h halted=%b cnt=%0d fv=%b",
                   w, o.pc, o.src, o.tv, o.tpc, o.halted, o.cnt, o.fv,
                   e.pc, e.src, e.tv, e.tpc, e.halted, e.cnt, !e.halted);
        end
        cur_pc[w] = e.pc;
      end
    end else begin
      checks++;
      if (o.tv !== 1'b0) begin
        errors++;
        $display("FAIL trap_pulse dut%0d trap_valid=%b expected 0", w, o.tv);
      end
      if (o.fv) begin
        checks++;
        if (o.pc !== cur_pc[w]) begin
          errors++;
          $display("FAIL fetch_pc_hold dut%0d got %h expected %h", w, o.pc, cur_pc[w]);
        end
      end
      if (prev_h[w]) begin
        checks++;
        if (o.halted !== 1'b1 || o.fv !== 1'b0) begin
          errors++;
          $display("FAIL halt_sticky dut%0d halted=%b fetch_valid=%b expected 1/0",
                   w, o.halted, o.fv);
        end
      end
    end
    prev_fv[w] = o.fv;
    prev_h[w]  = o.halted;
  endtask

  always @(negedge clk) begin
    out_t oa;
    out_t ob;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_fv[i] = 1'b0;
        prev_h[i]  = 1'b0;
        cur_pc[i]  = RST_PC;
      end
    end else begin
      oa = '{fv: fv_a, pc: fpc_a, tv: tv_a, tpc: tpc_a, src: src_a, halted: hlt_a, cnt: cnt_a};
      ob = '{fv: fv_b, pc: fpc_b, tv: tv_b, tpc: tpc_b, src: src_b, halted: hlt_b,
             cnt: 32'(cnt_b)};
      mon_side(0, oa);
      mon_side(1, ob);
    end
  end

  task automatic check_reset_vals();
    checks++;
    if (fv_a !== 1'b0 || fpc_a !== RST_PC || tv_a !== 1'b0 || tpc_a !== '0 ||
        src_a !== 2'd0 || hlt_a !== 1'b0 || cnt_a !== '0) begin
      errors++;
      $display("FAIL reset_a got fv=%b pc=%h tv=%b tpc=%h src=%0d h=%b cnt=%0d expected 0/%h/0/0/0/0/0",
               fv_a, fpc_a, tv_a, tpc_a, src_a, hlt_a, cnt_a, RST_PC);
    end
    checks++;
    if (fv_b !== 1'b0 || fpc_b !== RST_PC || tv_b !== 1'b0 || tpc_b !== '0 ||
        src_b !== 2'd0 || hlt_b !== 1'b0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL reset_b got fv=%b pc=%h tv=%b tpc=%h src=%0d h=%b cnt=%0d expected 0/%h/0/0/0/0/0",
               fv_b, fpc_b, tv_b, tpc_b, src_b, hlt_b, cnt_b, RST_PC);
    end
  endtask

  task automatic do_reset();
    rec_t boot;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    fetch_ready = 1'b0;
    res_valid   = 1'b0;
    halt        = 1'b0;
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    boot = '{pc: RST_PC, src: 2'd0, tv: 1'b0, tpc: '0, halted: 1'b0, cnt: '0};
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  = RST_PC;
      m_cnt[i] = '0;
      m_tpc[i] = '0;
    end
    q_a.push_back(boot);
    q_b.push_back(boot);
    @(negedge clk);
    checks++;
    if (fv_a !== 1'b0 || fv_b !== 1'b0) begin
      errors++;
      $display("FAIL boot_gap fetch_valid a=%b b=%b expected 0", fv_a, fv_b);
    end
  endtask

  task automatic do_instr(input logic [2:0] b, input logic z, input logic l,
                          input logic [31:0] im, input logic [31:0] r1, input logic h);
    int   n;
    int   k;
    rec_t e;
    n = 0;
    while (!fv_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!fv_a) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout fetch_valid=%b expected 1 within 50 cycles", fv_a);
      return;
    end
    // Hold ready low for a while, with stray res_valid pulses that must be ignored.
    k = $urandom_range(0, 2);
    repeat (k) begin
      res_valid = 1'($urandom);
      branch    = 3'($urandom);
      zero      = 1'($urandom);
      less      = 1'($urandom);
      imm       = $urandom;
      rs1       = $urandom;
      @(negedge clk);
    end
    res_valid   = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clk);
    fetch_ready = 1'b0;
    k = $urandom_range(0, 2);
    repeat (k) @(negedge clk);
    branch    = b;
    zero      = z;
    less      = l;
    imm       = im;
    rs1       = r1;
    halt      = h;
    res_valid = 1'b1;
    e = predict(m_pc[0], m_cnt[0], m_tpc[0], 4, 64'h1_0000_0000, b, z, l, im, r1, h);
    q_a.push_back(e);
    m_pc[0] = e.pc; m_cnt[0] = e.cnt; m_tpc[0] = e.tpc;
    e = predict(m_pc[1], m_cnt[1], m_tpc[1], 2, 64'd16, b, z, l, im, r1, h);
    q_b.push_back(e);
    m_pc[1] = e.pc; m_cnt[1] = e.cnt; m_tpc[1] = e.tpc;
    @(negedge clk);
    res_valid = 1'b0;
    halt      = 1'b0;
  endtask

  task automatic rand_instr();
    logic [31:0] im;
    im = $urandom;
    if ($urandom_range(0, 1) == 1) im[1:0] = 2'b00;
    do_instr(3'($urandom), 1'($urandom), 1'($urandom), im, $urandom, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_instr(3'b100, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    do_instr(3'b010, 1'b0, 1'b0, 32'h0000_0002, 32'h8000_1001, 1'b0);
    do_instr(3'b111, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 1'b0);
    do_instr(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFC - m_pc[0], 32'h0, 1'b0);
    do_instr(3'b000, 1'b0, 1'b0, 32'h1234_5677, 32'h0, 1'b0);
    do_instr(3'b011, 1'b1, 1'b1, 32'h0000_0003, 32'h0, 1'b0);
    do_instr(3'b101, 1'b0, 1'b0, 32'h0000_0006, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) rand_instr();
    do_instr(3'b110, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 1'b1);
    repeat (8) @(negedge clk);
    do_reset();
    @(negedge clk);
    checks++;
    if (fv_a !== 1'b1) begin
      errors++;
      $display("FAIL fetch_after_boot fetch_valid=%b expected 1", fv_a);
    end
    do_reset();
    for (int i = 0; i < 6; i++) rand_instr();
    @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations a=%0d b=%0d expected 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
